mio_access_unit: RTL

MIO_ACCESS_UNIT -- requirements
Module: mio_access_unit

---
 rtl/mio_access_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mio_access_unit.sv
// Memory/IO access unit: sequences one aligned CPU load/store onto a
// ready-handshake bus, with lane steering, load extension and timeout.
module mio_access_unit #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_sign,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [DW-1:0]   rdata,
    output logic            bus_req,
    output logic            mem_w,
    output logic [AW-1:0]   Addr_out,
    output logic [DW-1:0]   Data_out,
    output logic [DW/8-1:0] be,
    input  logic            MIO_ready,
    input  logic [DW-1:0]   Data_in
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic [LB-1:0] r_lane;
    logic [1:0]    r_size;
    logic          r_sign;
    logic          r_we;

    logic [LB-1:0] w_lane;
    logic          w_misal;
    logic          w_illegal;

    assign w_lane    = req_addr[LB-1:0];
    assign w_illegal = (req_size == 2'b11) && (DW != 64);
    assign w_misal   = ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                     || ((req_size == 2'b11) && (req_addr[2:0] != 3'b000));

    function automatic logic [NB-1:0] f_be(input logic [1:0] sz,
                                           input logic [LB-1:0] ln);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (i < (1 << sz));
        return m << ln;
    endfunction

    // Store data is repeated every access-size bytes so any lane sees it.
    function automatic logic [DW-1:0] f_rep(input logic [1:0] sz,
                                            input logic [DW-1:0] wd);
        logic [DW-1:0] r;
        int            nb;
        nb = 1 << sz;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] f_ext(input logic [DW-1:0] d,
                                            input logic [LB-1:0] ln,
                                            input logic [1:0] sz,
                                            input logic sg);
        logic [DW-1:0] sh;
        logic [DW-1:0] r;
        logic          sb;
        int            top;
        sh  = d >> {ln, 3'b000};
        top = 8 << sz;
        if (top > DW) top = DW;
        unique case (sz)
            2'b00:   sb = sh[7];
            2'b01:   sb = sh[15];
            2'b10:   sb = sh[31];
            default: sb = sh[DW-1];
        endcase
        for (int j = 0; j < DW; j++) r[j] = (j < top) ? sh[j] : (sg & sb);
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_lane   <= '0;
            r_size   <= '0;
            r_sign   <= 1'b0;
            r_we     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            bus_req  <= 1'b0;
            mem_w    <= 1'b0;
            Addr_out <= '0;
            Data_out <= '0;
            be       <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (w_illegal || w_misal) begin
                            r_state <= S_RESP;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= '0;
                        end else begin
                            r_state  <= S_ACCESS;
                            r_cnt    <= '0;
                            r_lane   <= w_lane;
                            r_size   <= req_size;
                            r_sign   <= req_sign;
                            r_we     <= req_we;
                            bus_req  <= 1'b1;
                            mem_w    <= req_we;
                            Addr_out <= {req_addr[AW-1:LB], {LB{1'b0}}};
                            be       <= f_be(req_size, w_lane);
                            Data_out <= f_rep(req_size, req_wdata);
                        end
                    end
                end
                S_ACCESS: begin
                    // Ready is checked first so it wins over a same-edge timeout.
                    if (MIO_ready) begin
                        r_state <= S_RESP;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        rdata   <= r_we ? '0
                                        : f_ext(Data_in, r_lane, r_size, r_sign);
                        bus_req <= 1'b0;
                        mem_w   <= 1'b0;
                        be      <= '0;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state <= S_RESP;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                        bus_req <= 1'b0;
                        mem_w   <= 1'b0;
                        be      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
